// File: rtl/rf_pkg.sv
// Shared definitions for the rf register file: default width, register index
// enumeration and reset fill value.
package rf_pkg;

  localparam int unsigned RF_WIDTH = 8;
  localparam int unsigned RF_NREGS = 5;

  typedef enum logic [2:0] {
    REG_A = 3'd0,
    REG_B = 3'd1,
    REG_C = 3'd2,
    REG_D = 3'd3,
    REG_F = 3'd4
  } reg_idx_e;

  localparam logic RF_RST_BIT = 1'b0;

endpackage

// File: rtl/rf_reg.sv
// Single WIDTH-bit register with load enable and asynchronous active-low clear.
module rf_reg
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= {WIDTH{RF_RST_BIT}};
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rf.sv
// Five-register file (A, B, C, D, F) with a priority-muxed shared read bus.
// Optional RF_CONFLICT_DET_EN adds a 'conflict' output for multiple read enables.
module rf
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             ai,
  input  logic             bi,
  input  logic             ci,
  input  logic             di,
  input  logic             fi,
  input  logic             ao,
  input  logic             bo,
  input  logic             co,
  // 'do' is a reserved word in SystemVerilog, so the D output enable is do_
  input  logic             do_,
  input  logic             fo,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] fq,
  output logic [WIDTH-1:0] fod
`ifdef RF_CONFLICT_DET_EN
  ,
  output logic             conflict
`endif
);

  logic [RF_NREGS-1:0] ld;
  logic [RF_NREGS-1:0] oe;
  logic [WIDTH-1:0]    regs [RF_NREGS];
  reg_idx_e            sel;
  logic                hit;

  // Bit positions follow reg_idx_e, so bit 0 is A and the highest priority
  assign ld = {fi, di, ci, bi, ai};
  assign oe = {fo, do_, co, bo, ao};

  for (genvar i = 0; i < RF_NREGS; i++) begin : g_reg
    rf_reg #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .ld  (ld[i]),
      .d   (d),
      .q   (regs[i])
    );
  end

  always_comb begin
    sel = REG_A;
    hit = 1'b0;
    for (int unsigned i = 0; i < RF_NREGS; i++) begin
      if (!hit && oe[i]) begin
        hit = 1'b1;
        sel = reg_idx_e'(i[2:0]);
      end
    end
    p = hit ? regs[sel] : '0;
  end

  assign fq  = regs[REG_F];
  assign fod = fo ? regs[REG_F] : '0;

`ifdef RF_CONFLICT_DET_EN
  assign conflict = ($countones(oe) > 1);
`endif

endmodule

// File: tb/tb_rf.sv
// Scoreboard bench for rf: driver pushes expected outputs from a reference
// model, a negedge monitor pops and compares.
module tb_rf;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       ai, bi, ci, di, fi;
  logic       ao, bo, co, do_, fo;
  logic [7:0] p, fq, fod;
`ifdef RF_CONFLICT_DET_EN
  logic       conflict;
`endif

  rf #(.WIDTH(8)) dut (
    .clk (clk), .rst (rst), .d (d),
    .ai (ai), .bi (bi), .ci (ci), .di (di), .fi (fi),
    .ao (ao), .bo (bo), .co (co), .do_ (do_), .fo (fo),
    .p (p), .fq (fq), .fod (fod)
`ifdef RF_CONFLICT_DET_EN
    , .conflict (conflict)
`endif
  );

  typedef struct {
    int         id;
    logic [7:0] p;
    logic [7:0] fq;
    logic [7:0] fod;
    logic       cf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [5];   // model contents, index 0..4 = A,B,C,D,F
  int         vectors = 0;
  int         miscompares = 0;
  int         issued = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ld/oe bit order: {F,D,C,B,A}
  task automatic apply(input logic r, input logic [7:0] dv,
                       input logic [4:0] l, input logic [4:0] o);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    rst = r;
    d   = dv;
    {fi, di, ci, bi, ai} = l;
    {fo, do_, co, bo, ao} = o;
    if (!r) for (int i = 0; i < 5; i++) m[i] = 8'd0;
    e.id  = issued;
    e.p   = 8'd0;
    for (int i = 4; i >= 0; i--) if (o[i]) e.p = m[i];
    e.fq  = m[4];
    e.fod = o[4] ? m[4] : 8'd0;
    n = 0;
    for (int i = 0; i < 5; i++) n += int'(o[i]);
    e.cf  = (n >= 2);
    sb.push_back(e);
    issued++;
    if (r) for (int i = 0; i < 5; i++) if (l[i]) m[i] = dv;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (p !== e.p) begin
        miscompares++;
        $display("FAIL p vec%0d: got %0d expected %0d", e.id, p, e.p);
      end
      if (fq !== e.fq) begin
        miscompares++;
        $display("FAIL fq vec%0d: got %0d expected %0d", e.id, fq, e.fq);
      end
      if (fod !== e.fod) begin
        miscompares++;
        $display("FAIL fod vec%0d: got %0d expected %0d", e.id, fod, e.fod);
      end
`ifdef RF_CONFLICT_DET_EN
      if (conflict !== e.cf) begin
        miscompares++;
        $display("FAIL conflict vec%0d: got %0b expected %0b", e.id, conflict, e.cf);
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] l, o;
    logic       r;
    rst = 1'b0; d = 8'd0;
    {fi, di, ci, bi, ai} = 5'd0;
    {fo, do_, co, bo, ao} = 5'd0;
    for (int i = 0; i < 5; i++) m[i] = 8'd0;

    // reset state with all read enables asserted
    apply(1'b0, 8'hFF, 5'b11111, 5'b11111);
    apply(1'b0, 8'h00, 5'b00000, 5'b10000);

    // dual load and read
    apply(1'b1, 8'd100, 5'b00011, 5'b00000);
    apply(1'b1, 8'd0,   5'b00000, 5'b00001);
    apply(1'b1, 8'd0,   5'b00000, 5'b00010);
    apply(1'b1, 8'd0,   5'b00000, 5'b00000);

    // single load, no read bypass
    apply(1'b1, 8'd64,  5'b00100, 5'b00000);
    apply(1'b1, 8'd4,   5'b10000, 5'b00100);
    apply(1'b1, 8'd0,   5'b00000, 5'b00000);

    // F outputs
    apply(1'b1, 8'd0,   5'b00000, 5'b10000);
    apply(1'b1, 8'd0,   5'b00000, 5'b00000);

    // priority
    apply(1'b1, 8'd1,   5'b00001, 5'b00000);
    apply(1'b1, 8'd2,   5'b00010, 5'b00000);
    apply(1'b1, 8'd0,   5'b00000, 5'b00011);
    apply(1'b1, 8'd0,   5'b00000, 5'b11110);
    apply(1'b1, 8'd7,   5'b01000, 5'b00000);
    apply(1'b1, 8'd0,   5'b00000, 5'b01000);

    // async reset mid-cycle, load blocked until release and next edge
    apply(1'b0, 8'd9,   5'b00001, 5'b11111);
    apply(1'b0, 8'd9,   5'b00001, 5'b00001);
    apply(1'b1, 8'd9,   5'b00001, 5'b00001);
    apply(1'b1, 8'd0,   5'b00000, 5'b00001);

    // randomized traffic with occasional reset pulses
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 29) != 0);
      l = 5'($urandom) & 5'($urandom);
      case ($urandom_range(0, 3))
        0:       o = 5'd0;
        1, 2:    o = 5'd1 << $urandom_range(0, 4);
        default: o = 5'($urandom);
      endcase
      apply(r, 8'($urandom), l, o);
    end

    for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    if (vectors != issued) begin
      miscompares++;
      $display("FAIL count: got %0d checked expected %0d", vectors, issued);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
